// File: rtl/spike_result_collector.sv
// spike_result_collector
// Collects the grid's per-tick spike packets into a frame vector, skips the
// frames produced while the layered pipeline fills, votes the winning class
// one class per cycle, and queues {picture, spikes, class} in a 2-entry
// valid/ready FIFO for readout.
module spike_result_collector #(
  parameter int NUM_OUTPUT  = 250,
  parameter int NUM_CLASSES = 10,
  parameter int NUM_PICTURE = 10000,
  parameter int LATENCY     = 2,
  parameter int PIC_W       = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic                  packet_out_valid,
  input  logic [7:0]            packet_out,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [PIC_W-1:0]      result_picture,
  output logic [NUM_OUTPUT-1:0] result_spikes,
  output logic [3:0]            result_class,
  output logic                  done,
  output logic                  index_error,
  output logic                  drop_error
);

  // Neurons per class group and the width of a group's vote count.
  localparam int G      = NUM_OUTPUT / NUM_CLASSES;
  localparam int CNT_W  = $clog2(G + 1);
  // Tick counter only needs to tell "still filling" from "pipeline full".
  localparam int TICK_W = $clog2(LATENCY + 2);
  localparam int SUM_W  = PIC_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_COUNT = 2'd1;
  localparam logic [1:0] S_PUSH  = 2'd2;

  // Number of set bits in one class group.
  function automatic logic [CNT_W-1:0] popcount(input logic [G-1:0] bits);
    logic [CNT_W-1:0] acc;
    acc = '0;
    for (int i = 0; i < G; i++) begin
      acc = acc + CNT_W'(bits[i]);
    end
    return acc;
  endfunction

  // Tick counter increment that stops once the pipeline is known to be full.
  function automatic logic [TICK_W-1:0] tick_sat_inc(input logic [TICK_W-1:0] v);
    logic [TICK_W-1:0] r;
    if (v == TICK_W'(LATENCY + 1)) begin
      r = v;
    end else begin
      r = v + TICK_W'(1);
    end
    return r;
  endfunction

  // Capture side
  logic [NUM_OUTPUT-1:0] cap;
  logic [NUM_OUTPUT-1:0] cap_nxt;
  logic [TICK_W-1:0]     tick_cnt;
  logic [TICK_W-1:0]     tick_cnt_nxt;
  logic                  pkt_ok;
  logic                  pkt_bad;

  // Frame hand-off and voting
  logic                  frame_acc;
  logic                  frame_busy;
  logic [1:0]            state;
  logic [NUM_OUTPUT-1:0] snap;
  logic [NUM_OUTPUT-1:0] work;
  logic [3:0]            cls_idx;
  logic [3:0]            best_cls;
  logic [CNT_W-1:0]      best_cnt;
  logic [CNT_W-1:0]      grp_cnt;
  logic                  last_cls;
  logic                  in_push;

  // Picture accounting
  logic [PIC_W-1:0]      pic_cnt;
  logic [SUM_W-1:0]      pic_sum;

  // Result FIFO
  logic [PIC_W-1:0]      fifo_pic [2];
  logic [NUM_OUTPUT-1:0] fifo_spk [2];
  logic [3:0]            fifo_cls [2];
  logic [1:0]            fifo_cnt;
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic                  fifo_full;
  logic                  pop;
  logic                  push_ok;

  assign pkt_ok  = packet_out_valid && (int'(packet_out) < NUM_OUTPUT);
  assign pkt_bad = packet_out_valid && (int'(packet_out) >= NUM_OUTPUT);

  assign tick_cnt_nxt = tick_sat_inc(tick_cnt);

  // A frame is kept only once the pipeline has filled and the run is not over.
  assign frame_acc  = tick && !done && (tick_cnt_nxt > TICK_W'(LATENCY));
  assign frame_busy = frame_acc && (state != S_IDLE);

  // The current class group always sits at the top of the shifting copy.
  assign grp_cnt  = popcount(work[NUM_OUTPUT-1 -: G]);
  assign last_cls = (cls_idx == 4'(NUM_CLASSES - 1));
  assign in_push  = (state == S_PUSH);

  assign fifo_full = (fifo_cnt == 2'd2);
  assign pop       = result_valid && result_ready;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push_ok   = in_push && (!fifo_full || pop);

  // A push and a drop can land together when a frame arrives during PUSH.
  assign pic_sum = {1'b0, pic_cnt} + SUM_W'(in_push) + SUM_W'(frame_busy);

  // Next capture vector: cleared by tick, then this cycle's packet is ORed in
  // so a packet coinciding with tick lands in the new frame.
  always_comb begin
    cap_nxt = tick ? '0 : cap;
    for (int n = 0; n < NUM_OUTPUT; n++) begin
      if (pkt_ok && (int'(packet_out) == n)) begin
        cap_nxt[NUM_OUTPUT-1-n] = 1'b1;
      end
    end
  end

  // Capture vector, fill counter and the out-of-range packet flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap         <= '0;
      tick_cnt    <= '0;
      index_error <= 1'b0;
    end else begin
      cap <= cap_nxt;
      if (tick) begin
        tick_cnt <= tick_cnt_nxt;
      end
      if (pkt_bad) begin
        index_error <= 1'b1;
      end
    end
  end

  // Voting FSM: snapshot on an accepted frame, one class group per cycle,
  // strict greater-than so ties keep the lowest class, then one push cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      snap     <= '0;
      work     <= '0;
      cls_idx  <= '0;
      best_cls <= '0;
      best_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (frame_acc) begin
            snap     <= cap;
            work     <= cap;
            cls_idx  <= '0;
            best_cls <= '0;
            best_cnt <= '0;
            state    <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (grp_cnt > best_cnt) begin
            best_cls <= cls_idx;
            best_cnt <= grp_cnt;
          end
          work    <= work << G;
          cls_idx <= cls_idx + 4'd1;
          if (last_cls) begin
            state <= S_PUSH;
          end
        end
        S_PUSH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Picture numbering advances for every frame that was pushed or lost so the
  // index always matches the input picture; done and drop_error are sticky.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pic_cnt    <= '0;
      done       <= 1'b0;
      drop_error <= 1'b0;
    end else begin
      pic_cnt <= pic_sum[PIC_W-1:0];
      if (pic_sum >= SUM_W'(NUM_PICTURE)) begin
        done <= 1'b1;
      end
      if (frame_busy || (in_push && !push_ok)) begin
        drop_error <= 1'b1;
      end
    end
  end

  // Two-entry result FIFO; the head stays put until it is popped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) begin
        fifo_pic[i] <= '0;
        fifo_spk[i] <= '0;
        fifo_cls[i] <= '0;
      end
      fifo_cnt <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
    end else begin
      if (push_ok) begin
        fifo_pic[wr_ptr] <= pic_cnt;
        fifo_spk[wr_ptr] <= snap;
        fifo_cls[wr_ptr] <= best_cls;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push_ok, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 2'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 2'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  assign result_valid   = (fifo_cnt != 2'd0);
  assign result_picture = fifo_pic[rd_ptr];
  assign result_spikes  = fifo_spk[rd_ptr];
  assign result_class   = fifo_cls[rd_ptr];

endmodule

// File: tb/tb_spike_result_collector.sv
// Bench for spike_result_collector: a cycle-stepped reference model of the
// collector's rules, a table of hand-voted frames, and directed sequences for
// back-pressure, index errors, reset during voting and end-of-run.
module tb_spike_result_collector;

  localparam int NO  = 250;
  localparam int NC  = 10;
  localparam int G   = NO / NC;
  localparam int LAT = 2;
  localparam int PW  = 16;
  localparam int NP  = 10000;

  logic clk;
  logic reset_n, reset4_n;
  logic tick, packet_out_valid, result_ready;
  logic [7:0] packet_out;

  logic          rv, done, ierr, derr;
  logic [PW-1:0] rpic;
  logic [NO-1:0] rspk;
  logic [3:0]    rcls;

  logic          rv4, done4, ierr4, derr4;
  logic [PW-1:0] rpic4;
  logic [NO-1:0] rspk4;
  logic [3:0]    rcls4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  spike_result_collector #(
    .NUM_OUTPUT(NO), .NUM_CLASSES(NC), .NUM_PICTURE(NP), .LATENCY(LAT), .PIC_W(PW)
  ) dut (
    .clk(clk), .reset_n(reset_n), .tick(tick),
    .packet_out_valid(packet_out_valid), .packet_out(packet_out),
    .result_valid(rv), .result_ready(result_ready),
    .result_picture(rpic), .result_spikes(rspk), .result_class(rcls),
    .done(done), .index_error(ierr), .drop_error(derr)
  );

  spike_result_collector #(
    .NUM_OUTPUT(NO), .NUM_CLASSES(NC), .NUM_PICTURE(4), .LATENCY(LAT), .PIC_W(PW)
  ) dut4 (
    .clk(clk), .reset_n(reset4_n), .tick(tick),
    .packet_out_valid(packet_out_valid), .packet_out(packet_out),
    .result_valid(rv4), .result_ready(result_ready),
    .result_picture(rpic4), .result_spikes(rspk4), .result_class(rcls4),
    .done(done4), .index_error(ierr4), .drop_error(derr4)
  );

  int n_pass;
  int n_total;

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [PW-1:0] pic;
    logic [NO-1:0] spk;
    logic [3:0]    cls;
  } res_t;

  res_t m_q[$];
  res_t m_pend;
  bit   m_frame [NO];
  int   m_ticks, m_pic, m_left;
  bit   m_busy, m_done, m_ierr, m_derr;

  logic [PW-1:0] d4_pic[$];
  logic          d4_done[$];

  task automatic chk(input string name, input logic [NO-1:0] act, input logic [NO-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    m_q.delete();
    for (int n = 0; n < NO; n++) m_frame[n] = 1'b0;
    m_ticks = 0; m_pic = 0; m_left = 0;
    m_busy = 0; m_done = 0; m_ierr = 0; m_derr = 0;
    m_pend = '0;
  endtask

  // Applies the inputs that the DUT will sample at the coming clock edge.
  task automatic model_step();
    bit busy_old, done_old;
    int votes [NC];
    int best;
    busy_old = m_busy;
    done_old = m_done;
    if (m_q.size() > 0 && result_ready) m_q.delete(0);
    if (m_busy) begin
      m_left--;
      if (m_left == 0) begin
        m_busy = 0;
        m_pend.pic = PW'(m_pic);
        m_pic++;
        if (m_q.size() < 2) m_q.push_back(m_pend);
        else m_derr = 1;
      end
    end
    if (tick) begin
      m_ticks++;
      if (!done_old && m_ticks > LAT) begin
        if (busy_old) begin
          m_derr = 1;
          m_pic++;
        end else begin
          for (int c = 0; c < NC; c++) votes[c] = 0;
          m_pend.spk = '0;
          for (int n = 0; n < NO; n++) begin
            if (m_frame[n]) begin
              votes[n / G]++;
              m_pend.spk[NO-1-n] = 1'b1;
            end
          end
          best = 0;
          for (int c = 1; c < NC; c++) if (votes[c] > votes[best]) best = c;
          m_pend.cls = 4'(best);
          m_busy = 1;
          m_left = NC + 1;
        end
      end
      for (int n = 0; n < NO; n++) m_frame[n] = 1'b0;
    end
    if (packet_out_valid) begin
      if (int'(packet_out) < NO) m_frame[packet_out] = 1'b1;
      else m_ierr = 1;
    end
    if (m_pic >= NP) m_done = 1;
  endtask

  task automatic compare_all();
    chk("result_valid", rv, (m_q.size() > 0));
    if (m_q.size() > 0) begin
      chk("result_picture", rpic, m_q[0].pic);
      chk("result_spikes", rspk, m_q[0].spk);
      chk("result_class", rcls, m_q[0].cls);
    end
    chk("index_error", ierr, m_ierr);
    chk("drop_error", derr, m_derr);
    chk("done", done, m_done);
  endtask

  // One clock: model sees the pending inputs, DUT samples them, then compare.
  task automatic cyc();
    if (reset4_n && rv4 && result_ready) begin
      d4_pic.push_back(rpic4);
      d4_done.push_back(done4);
    end
    if (reset_n) model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) cyc();
  endtask

  task automatic send_pkt(input int n);
    packet_out_valid = 1'b1;
    packet_out = 8'(n);
    cyc();
    packet_out_valid = 1'b0;
  endtask

  task automatic send_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, output int lat);
    lat = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      cyc();
      if (rv) begin
        lat = i;
        break;
      end
    end
    chk("wait_valid_timeout", (lat != 0), 1'b1);
  endtask

  // ---------------- directed frame table ----------------
  typedef struct packed {
    logic [3:0]      cnt;
    logic [7:0][7:0] nrn;
    logic [3:0]      cls;
  } vec_t;

  function automatic vec_t mk(input int cnt, input int n0, input int n1, input int n2,
                              input int n3, input int n4, input int n5, input int n6,
                              input int cls);
    vec_t v;
    v = '0;
    v.cnt = 4'(cnt);
    v.nrn[0] = 8'(n0); v.nrn[1] = 8'(n1); v.nrn[2] = 8'(n2); v.nrn[3] = 8'(n3);
    v.nrn[4] = 8'(n4); v.nrn[5] = 8'(n5); v.nrn[6] = 8'(n6);
    v.cls = 4'(cls);
    return v;
  endfunction

  vec_t tbl [6];

  initial begin
    int lat;
    logic [NO-1:0] exp_spk;
    n_pass = 0;
    n_total = 0;

    tbl[0] = mk(4, 0, 1, 2, 60, 0, 0, 0, 0);
    tbl[1] = mk(6, 25, 30, 49, 100, 110, 124, 0, 1);
    tbl[2] = mk(7, 25, 30, 49, 100, 110, 124, 101, 4);
    tbl[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[4] = mk(3, 249, 248, 225, 0, 0, 0, 0, 9);
    tbl[5] = mk(3, 50, 75, 76, 0, 0, 0, 0, 3);

    reset_n = 1'b0; reset4_n = 1'b0;
    tick = 1'b0; packet_out_valid = 1'b0; packet_out = '0; result_ready = 1'b0;
    model_reset();
    #1;
    chk("reset_valid", rv, 1'b0);
    chk("reset_flags", {done, ierr, derr}, 3'b000);
    idle(3);
    reset_n = 1'b1;
    cyc();

    // pipeline fill: ticks 1 and 2 produce nothing
    send_pkt(5);
    send_tick();
    idle(3);
    send_pkt(30);
    send_tick();
    idle(14);
    chk("fill_no_result", rv, 1'b0);

    // hand-voted frames, pictures 0..5
    result_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      exp_spk = '0;
      for (int k = 0; k < int'(tbl[i].cnt); k++) begin
        send_pkt(int'(tbl[i].nrn[k]));
        exp_spk[NO-1-int'(tbl[i].nrn[k])] = 1'b1;
      end
      send_tick();
      wait_valid(20, lat);
      if (i == 0) chk("tick_to_valid_latency", lat + 1, NC + 2);
      chk("tbl_picture", rpic, PW'(i));
      chk("tbl_spikes", rspk, exp_spk);
      chk("tbl_class", rcls, tbl[i].cls);
      cyc();
    end

    // back-pressure: pictures 6,7 held, 8 lost
    result_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      send_pkt(10 + j);
      send_tick();
      idle(13);
    end
    chk("bp_drop_error", derr, 1'b1);
    for (int j = 0; j < 3; j++) begin
      chk("bp_head_stable", rpic, PW'(6));
      cyc();
    end
    result_ready = 1'b1;
    chk("bp_pop_first", rpic, PW'(6));
    cyc();
    chk("bp_pop_second", rpic, PW'(7));
    cyc();
    chk("bp_empty", rv, 1'b0);
    send_tick();
    wait_valid(20, lat);
    chk("bp_next_picture", rpic, PW'(9));
    cyc();

    // out-of-range index, and a packet coinciding with tick
    send_pkt(250);
    chk("index_error_set", ierr, 1'b1);
    send_pkt(0);
    tick = 1'b1; packet_out_valid = 1'b1; packet_out = 8'd7;
    cyc();
    tick = 1'b0; packet_out_valid = 1'b0;
    wait_valid(20, lat);
    chk("same_tick_bit_absent", rspk[242], 1'b0);
    chk("same_tick_own_bit", rspk[249], 1'b1);
    cyc();
    send_tick();
    wait_valid(20, lat);
    chk("same_tick_bit_next", rspk[242], 1'b1);
    chk("same_tick_next_pic", rpic, PW'(11));
    cyc();

    // randomized traffic against the model
    for (int f = 0; f < 30; f++) begin
      int gap;
      gap = $urandom_range(4, 20);
      for (int k = 0; k < gap; k++) begin
        packet_out_valid = ($urandom_range(0, 2) != 0);
        packet_out = 8'($urandom_range(0, 255));
        result_ready = ($urandom_range(0, 3) != 0);
        cyc();
      end
      packet_out_valid = ($urandom_range(0, 1) != 0);
      packet_out = 8'($urandom_range(0, 249));
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      packet_out_valid = 1'b0;
    end
    result_ready = 1'b1;
    idle(30);

    // reset while voting clears FSM and FIFO at once
    result_ready = 1'b0;
    send_pkt(3);
    send_tick();
    idle(12);
    send_tick();
    idle(4);
    chk("pre_reset_valid", rv, 1'b1);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_reset_valid", rv, 1'b0);
    chk("async_reset_flags", {done, ierr, derr}, 3'b000);
    chk("async_reset_head", {rpic, rcls}, '0);
    idle(2);
    reset_n = 1'b1;
    cyc();

    // end of run on the 4-picture instance
    result_ready = 1'b1;
    reset4_n = 1'b1;
    cyc();
    for (int j = 0; j < 8; j++) begin
      send_pkt(j * 20);
      send_tick();
      idle(15);
    end
    idle(20);
    chk("done_result_count", d4_pic.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (d4_pic.size() > k) begin
        chk("done_picture_seq", d4_pic[k], PW'(k));
        chk("done_at_push", d4_done[k], (k == 3));
      end
    end
    chk("done_sticky", done4, 1'b1);
    chk("done_no_drop", derr4, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
